maxpool2d_scheduler: RTL and testbench

MAXPOOL2D_SCHEDULER -- requirements
Module: maxpool2d_scheduler

---
 rtl/maxpool2d_scheduler_pkg.sv | 28 ++
 rtl/maxpool2d_scheduler_max_cmp.sv | 12 +
 rtl/maxpool2d_scheduler.sv | 140 ++++++++++++++
 tb/tb_maxpool2d_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2d_scheduler_pkg.sv
// Shared constants for the pooling scheduler: FSM encoding, layer dimensions and window size.
// The convolution scheduler draws its layer dimensions from the same constants.
package maxpool2d_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_FINAL,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int unsigned L0_IN_DIM  = 24;
    localparam int unsigned L0_OUT_DIM = 12;
    localparam int unsigned L1_IN_DIM  = 8;
    localparam int unsigned L1_OUT_DIM = 4;
    localparam int unsigned POOL_WIN   = 2;
    localparam int unsigned COORD_W    = 4;

    function automatic int unsigned in_dim(input logic m);
        return m ? L1_IN_DIM : L0_IN_DIM;
    endfunction

    function automatic int unsigned out_dim(input logic m);
        return m ? L1_OUT_DIM : L0_OUT_DIM;
    endfunction

endpackage

// File: rtl/maxpool2d_scheduler_max_cmp.sv
// Signed two-input maximum; on a tie the incumbent a_i is kept.
module max_cmp #(
    parameter int DATA_BIT = 8
) (
    input  logic [DATA_BIT-1:0] a_i,
    input  logic [DATA_BIT-1:0] b_i,
    output logic [DATA_BIT-1:0] max_o
);

    assign max_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;

endmodule

// File: rtl/maxpool2d_scheduler.sv
// 2x2 stride-2 max-pool scheduler: reads each window from a synchronous source memory,
// keeps a running signed maximum and writes one pooled pixel every 6 cycles.
module maxpool2d_scheduler
    import maxpool2d_scheduler_pkg::*;
#(
    parameter int ADDR_BIT      = 10,
    parameter int DATA_BIT      = 8,
    parameter int DST_BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    output logic [ADDR_BIT-1:0] src_mem_addr,
    input  logic [DATA_BIT-1:0] src_mem_rdata,
    output logic [ADDR_BIT-1:0] dst_mem_addr,
    output logic [DATA_BIT-1:0] dst_mem_wdata,
    output logic                dst_mem_we,
    output logic                busy,
    output logic                done
);

    state_e               state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic [DATA_BIT-1:0]  max_q, max_d;
    logic                 mode_q, mode_d;

    logic [DATA_BIT-1:0]  cmp_max;
    logic [ADDR_BIT-1:0]  in_dim_a, out_dim_a, row_a, col_a, src_addr, dst_addr;
    logic [COORD_W-1:0]   last_c;
    logic                 last_win;

    // Address arithmetic carried at full ADDR_BIT width so the 24x24 map cannot truncate.
    assign in_dim_a  = ADDR_BIT'(in_dim(mode_q));
    assign out_dim_a = ADDR_BIT'(out_dim(mode_q));
    assign row_a     = ADDR_BIT'(oy_q) * ADDR_BIT'(POOL_WIN) + ADDR_BIT'(k_q[1]);
    assign col_a     = ADDR_BIT'(ox_q) * ADDR_BIT'(POOL_WIN) + ADDR_BIT'(k_q[0]);
    assign src_addr  = row_a * in_dim_a + col_a;
    assign dst_addr  = ADDR_BIT'(DST_BASE_ADDR) + ADDR_BIT'(oy_q) * out_dim_a + ADDR_BIT'(ox_q);

    assign last_c   = COORD_W'(out_dim(mode_q) - 1);
    assign last_win = (ox_q == last_c) && (oy_q == last_c);

    max_cmp #(.DATA_BIT(DATA_BIT)) u_max_cmp (
        .a_i   (max_q),
        .b_i   (src_mem_rdata),
        .max_o (cmp_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            max_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        max_d         = max_q;
        mode_d        = mode_q;
        src_mem_addr  = '0;
        dst_mem_addr  = '0;
        dst_mem_wdata = '0;
        dst_mem_we    = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_READ;
                    k_d     = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                    mode_d  = mode;
                end
            end
            ST_READ: begin
                src_mem_addr = src_addr;
                // Read data lags the address by one cycle, so k selects the previous sample.
                if (k_q == 2'd1) begin
                    max_d = src_mem_rdata;
                end else if (k_q != 2'd0) begin
                    max_d = cmp_max;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                max_d   = cmp_max;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                dst_mem_we    = 1'b1;
                dst_mem_wdata = max_q;
                dst_mem_addr  = dst_addr;
                k_d           = '0;
                if (last_win) begin
                    ox_d    = '0;
                    oy_d    = '0;
                    state_d = ST_DONE;
                end else if (ox_q == last_c) begin
                    ox_d    = '0;
                    oy_d    = oy_q + COORD_W'(1);
                    state_d = ST_READ;
                end else begin
                    ox_d    = ox_q + COORD_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_maxpool2d_scheduler.sv
// Directed bench for maxpool2d_scheduler: two instances (base 0 and base 576) share stimulus and source data.
module tb_maxpool2d_scheduler;

    localparam int AB = 10;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst_n, start, mode;
    logic [AB-1:0] src_addr0, src_addr1, dst_addr0, dst_addr1;
    logic [DB-1:0] rdata0, rdata1, wdata0, wdata1;
    logic we0, we1, busy0, busy1, done0, done1;

    logic [7:0] src  [0:1023];
    logic [7:0] dst0 [0:1023];
    logic [7:0] dst1 [0:1023];
    int wr_log0 [0:4095];
    int wr_log1 [0:4095];
    int wr_cnt0 = 0, wr_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
    int n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic [7:0] w0, w1, w2, w3, exp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    maxpool2d_scheduler #(.ADDR_BIT(AB), .DATA_BIT(DB), .DST_BASE_ADDR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_mem_addr(src_addr0), .src_mem_rdata(rdata0),
        .dst_mem_addr(dst_addr0), .dst_mem_wdata(wdata0), .dst_mem_we(we0),
        .busy(busy0), .done(done0)
    );

    maxpool2d_scheduler #(.ADDR_BIT(AB), .DATA_BIT(DB), .DST_BASE_ADDR(576)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_mem_addr(src_addr1), .src_mem_rdata(rdata1),
        .dst_mem_addr(dst_addr1), .dst_mem_wdata(wdata1), .dst_mem_we(we1),
        .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        rdata0 <= src[src_addr0];
        rdata1 <= src[src_addr1];
    end

    always @(posedge clk) begin
        if (we0 === 1'b1) begin
            dst0[dst_addr0] = wdata0;
            wr_log0[wr_cnt0 % 4096] = int'(dst_addr0);
            wr_cnt0++;
        end
        if (we1 === 1'b1) begin
            dst1[dst_addr1] = wdata1;
            wr_log1[wr_cnt1 % 4096] = int'(dst_addr1);
            wr_cnt1++;
        end
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; bounded so a hung DUT still reaches the summary.
    task automatic wait_idle(output int cyc, output int done_at);
        cyc     = 0;
        done_at = -1;
        while (busy0 === 1'b1 && cyc < 3000) begin
            cyc++;
            if (done0 === 1'b1) done_at = cyc;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, done_at, b0, b1, d0, d1, bad, wsnap;

        vecs[0] = '{8'hFB, 8'hFD, 8'h80, 8'hF9, 8'hFD};
        vecs[1] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h09, 8'h09};
        vecs[3] = '{8'h09, 8'h03, 8'h02, 8'h01, 8'h09};
        vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        vecs[5] = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h7F};
        vecs[6] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};
        vecs[7] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};

        for (int i = 0; i < 1024; i++) begin
            src[i]  = 8'h00;
            dst0[i] = 8'h00;
            dst1[i] = 8'h00;
        end

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        #1;
        chk("rst_src_addr",  int'(src_addr0), 0);
        chk("rst_dst_addr",  int'(dst_addr0), 0);
        chk("rst_dst_wdata", int'(wdata0), 0);
        chk("rst_dst_we",    int'(we0), 0);
        chk("rst_busy",      int'(busy0), 0);
        chk("rst_done",      int'(done0), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start_busy", int'(busy0), 0);

        // Single-window table in mode 1: window 0 lives at addresses 0,1,8,9; background is -1.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 1024; i++) src[i] = 8'hFF;
            src[0] = vecs[t].w0;
            src[1] = vecs[t].w1;
            src[8] = vecs[t].w2;
            src[9] = vecs[t].w3;
            b0 = wr_cnt0;
            b1 = wr_cnt1;
            d0 = done_cnt0;
            d1 = done_cnt1;
            pulse_start(1'b1);
            wait_idle(cyc, done_at);
            chk($sformatf("v%0d_busy_cycles", t), cyc, 97);
            chk($sformatf("v%0d_done_at", t), done_at, 97);
            chk($sformatf("v%0d_writes", t), wr_cnt0 - b0, 16);
            chk($sformatf("v%0d_done_pulses", t), done_cnt0 - d0, 1);
            chk($sformatf("v%0d_win0_max", t), int'(dst0[0]), int'(vecs[t].exp));
            bad = 0;
            for (int j = 1; j < 16; j++) if (dst0[j] !== 8'hFF) bad++;
            chk($sformatf("v%0d_rest_ff_errors", t), bad, 0);
            bad = 0;
            for (int j = 0; j < 16; j++) if (wr_log0[(b0 + j) % 4096] != j) bad++;
            chk($sformatf("v%0d_addr_order_errors", t), bad, 0);
            if (t == 0) begin
                bad = 0;
                for (int j = 0; j < 16; j++) if (wr_log1[(b1 + j) % 4096] != 576 + j) bad++;
                chk("base576_addr_order_errors", bad, 0);
                chk("base576_writes", wr_cnt1 - b1, 16);
                chk("base576_done_pulses", done_cnt1 - d1, 1);
                chk("base576_win0_max", int'(dst1[576]), 253);
            end
        end

        // Mode 0 run aborted by an asynchronous reset at busy cycle 300.
        for (int i = 0; i < 1024; i++) src[i] = 8'((i % 576) % 128);
        pulse_start(1'b0);
        repeat (299) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_src_addr",  int'(src_addr0), 0);
        chk("midrst_dst_addr",  int'(dst_addr0), 0);
        chk("midrst_dst_wdata", int'(wdata0), 0);
        chk("midrst_dst_we",    int'(we0), 0);
        chk("midrst_busy",      int'(busy0), 0);
        chk("midrst_done",      int'(done0), 0);
        wsnap = wr_cnt0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_stays_idle", int'(busy0), 0);
        chk("midrst_no_writes", wr_cnt0 - wsnap, 0);

        // Clean full mode 0 run after the abort.
        b0 = wr_cnt0;
        d0 = done_cnt0;
        pulse_start(1'b0);
        wait_idle(cyc, done_at);
        chk("m0_busy_cycles", cyc, 865);
        chk("m0_done_at", done_at, 865);
        chk("m0_writes", wr_cnt0 - b0, 144);
        chk("m0_done_pulses", done_cnt0 - d0, 1);
        chk("m0_first_addr", wr_log0[b0 % 4096], 0);
        chk("m0_last_addr", wr_log0[(b0 + 143) % 4096], 143);
        chk("m0_dst0", int'(dst0[0]), 25);
        chk("m0_dst1", int'(dst0[1]), 27);
        chk("m0_dst143", int'(dst0[143]), 63);

        // start held high through a mode 1 run, mode flipped mid-run.
        b0 = wr_cnt0;
        d0 = done_cnt0;
        @(negedge clk);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy0 === 1'b1 && cyc < 3000) begin
            cyc++;
            if (cyc == 40) mode = 1'b0;
            @(negedge clk);
        end
        chk("held_busy_cycles", cyc, 97);
        chk("held_writes", wr_cnt0 - b0, 16);
        chk("held_done_pulses", done_cnt0 - d0, 1);
        chk("held_idle_gap_busy", int'(busy0), 0);
        @(negedge clk);
        chk("held_restart_busy", int'(busy0), 1);
        start = 1'b0;
        b0 = wr_cnt0;
        d0 = done_cnt0;
        wait_idle(cyc, done_at);
        chk("restart_busy_cycles", cyc, 865);
        chk("restart_writes", wr_cnt0 - b0, 144);
        chk("restart_done_pulses", done_cnt0 - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
